// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button/tick/time inputs and run-control outputs of the stopwatch sequencer
interface stopwatch_ctrl_if;
  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic        tick;
  logic [23:0] time_bcd;
  logic        divider_en;
  logic        count_en;
  logic        counter_clr;
  logic [23:0] disp_bcd;
  logic        disp_blank;
  logic [1:0]  state;
  logic        overflow;
  modport master (
    output btn_start, btn_lap, btn_clear, tick, time_bcd,
    input  divider_en, count_en, counter_clr, disp_bcd, disp_blank, state, overflow
  );
  modport slave (
    input  btn_start, btn_lap, btn_clear, tick, time_bcd,
    output divider_en, count_en, counter_clr, disp_bcd, disp_blank, state, overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/lap/pause sequencer for the mm:ss.cc stopwatch datapath
module stopwatch_ctrl #(
  parameter int          BLINK_TICKS = 50,
  parameter logic [23:0] MAX_TIME    = 24'h595999
) (
  input logic             clk,
  input logic             reset_n,
  stopwatch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, LAP = 2'b11, PAUSE = 2'b10} state_t;
  localparam int            BW    = $clog2(BLINK_TICKS);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_TICKS - 1);
  state_t        r_state;
  logic          r_start_q, r_lap_q, r_clear_q;
  logic          r_clr, r_blank, r_ovf;
  logic [23:0]   r_lap;
  logic [BW-1:0] r_blink;
  logic          w_se, w_clr, w_start, w_lap, w_top, w_hit, w_wrap;
  assign w_se    = bus.btn_start & ~r_start_q;
  assign w_clr   = bus.btn_clear & ~r_clear_q;
  assign w_start = w_se & ~w_clr;
  assign w_lap   = bus.btn_lap & ~r_lap_q & ~w_clr & ~w_se;
  assign w_top   = bus.time_bcd == MAX_TIME;
  assign w_hit   = bus.tick & w_top;
  assign w_wrap  = r_blink == BLAST;
  assign bus.count_en    = bus.tick & (r_state == RUN | r_state == LAP) & ~w_top;
  assign bus.divider_en  = r_state != IDLE;
  assign bus.disp_bcd    = r_state == LAP ? r_lap : bus.time_bcd;
  assign bus.counter_clr = r_clr;
  assign bus.disp_blank  = r_blank;
  assign bus.state       = r_state;
  assign bus.overflow    = r_ovf;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_start_q <= 1'b1;
      r_lap_q   <= 1'b1;
      r_clear_q <= 1'b1;
      r_clr     <= 1'b0;
      r_blank   <= 1'b0;
      r_ovf     <= 1'b0;
      r_lap     <= '0;
      r_blink   <= '0;
    end else begin
      r_start_q <= bus.btn_start;
      r_lap_q   <= bus.btn_lap;
      r_clear_q <= bus.btn_clear;
      r_clr     <= 1'b0;
      case (r_state)
        IDLE:
          if (w_clr) r_clr <= 1'b1;
          else if (w_start) r_state <= RUN;
        RUN, LAP:
          if (w_hit) begin
            r_ovf   <= 1'b1;
            r_state <= PAUSE;
          end else if (w_start) r_state <= PAUSE;
          else if (w_lap) begin
            if (r_state == RUN) r_lap <= bus.time_bcd;
            r_state <= r_state == RUN ? LAP : RUN;
          end
        PAUSE:
          if (w_clr) begin
            r_clr   <= 1'b1;
            r_ovf   <= 1'b0;
            r_state <= IDLE;
            r_blink <= '0;
            r_blank <= 1'b0;
          end else if (w_start && !r_ovf) begin
            r_state <= RUN;
            r_blink <= '0;
            r_blank <= 1'b0;
          end else if (bus.tick) begin
            r_blink <= w_wrap ? '0 : r_blink + 1'b1;
            r_blank <= r_blank ^ w_wrap;
          end
      endcase
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Run-control sequencer for the 6-digit mm:ss.cc stopwatch datapath: tick divider, three cascaded 2-digit BCD counter stages and the seven-segment driver.
- Converts debounced start/stop, lap and clear buttons into the following:
  - divider enable
  - gated count strobe
  - counter clear pulse
  - display source select (live/lap)
  - pause blink
- Stops the count at 59:59.99 rather than letting it wrap.

Parameters:
- BLINK_TICKS, 50, tick strobes per display blink half-period while paused (50 × 10 ms = 0.5 s); ≥ 2.
- MAX_TIME, 24'h595999, BCD time at which counting halts and overflow is flagged.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- btn_start, input, 1, debounced level; each rising edge requests run/pause toggle.
- btn_lap, input, 1, debounced level; rising edge requests lap freeze/release.
- btn_clear, input, 1, debounced level; rising edge requests zeroing.
- tick, input, 1, single-cycle 10 ms strobe from the divider.
- time_bcd, input, 24, live counter value {tens_min, ones_min, tens_sec, ones_sec, tens_ms, ones_ms}.
- divider_en, output, 1, enable to the tick divider.
- count_en, output, 1, enable to the least-significant counter stage.
- counter_clr, output, 1, one-cycle synchronous clear to all counter stages.
- disp_bcd, output, 24, time presented to the display driver.
- disp_blank, output, 1, blank all digits (pause blink).
- state, output, 2, IDLE=00, RUN=01, LAP=11, PAUSE=10.
- overflow, output, 1, sticky; set when MAX_TIME is reached.

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE; lap register=0; overflow=0; counter_clr=0; disp_blank=0; blink counter=0.
  - Button history registers = 1, so a button held through reset produces no edge.
- Edge detect: edge_x = btn_x & ~btn_x_q, with btn_x_q registered every clk.
  - The resulting state change is visible on the clk after the first cycle btn_x is sampled high.
- Edge priority when several occur in the same cycle: clear > start > lap. Lower-priority edges in that cycle are discarded.
- IDLE:
  - start → RUN.
  - clear → counter_clr pulse; stay IDLE.
  - lap ignored.
- RUN:
  - start → PAUSE.
  - lap → LAP; the lap register captures time_bcd on that edge cycle.
  - clear ignored.
- LAP (counting continues, display frozen):
  - lap → RUN.
  - start → PAUSE; display returns to live.
  - clear ignored.
  - A further lap capture requires a return to RUN first.
- PAUSE:
  - start → RUN, unless overflow=1, in which case start is ignored.
  - clear → counter_clr pulse, overflow cleared, → IDLE.
  - lap ignored.
- Overflow:
  - In RUN/LAP, a tick while time_bcd==MAX_TIME sets overflow and moves to PAUSE on the next clk.
  - count_en is suppressed for that tick, so the counters hold 59:59.99.
- count_en (combinational) = tick & (state==RUN | state==LAP) & (time_bcd != MAX_TIME).
- divider_en (combinational) = (state != IDLE). The divider keeps running in PAUSE to pace the blink.
- counter_clr is registered: high exactly one cycle, the clk after an accepted clear edge.
- disp_bcd (combinational) = lap register when state==LAP, else time_bcd.
- Blink (PAUSE only):
  - The blink counter increments on tick; at BLINK_TICKS-1 it wraps to 0 and disp_blank toggles.
  - On any exit from PAUSE: blink counter ← 0, disp_blank ← 0. disp_blank is always 0 outside PAUSE.
- Reset asserted mid-operation: all state returns to reset values immediately. The counters are reset by their own reset_n, not by counter_clr.

Test Plan:
- Reset, then pulse btn_start: state 00→01 on the clk after the edge; with ticks at 10 ms, count_en mirrors tick; divider_en=1.
- Running at time_bcd=24'h001234, pulse btn_lap: state=11, disp_bcd holds 24'h001234 while time_bcd advances. Second lap pulse: state=01, disp_bcd=time_bcd.
- In RUN pulse btn_start: state=10, count_en=0. After 50 ticks disp_blank=1; after 100 ticks disp_blank=0. Pulse btn_start: state=01, disp_blank=0.
- In PAUSE pulse btn_clear: counter_clr high for exactly 1 cycle, state=00. btn_clear in RUN: no pulse, state unchanged.
- Drive time_bcd=24'h595999 in RUN and pulse tick: count_en stays 0, overflow=1, state=10. btn_start ignored; btn_clear clears overflow and gives state=00.
- Hold btn_start high through reset release: no transition. Raise btn_start and btn_clear in the same cycle while in PAUSE: clear wins, state=00. Assert reset_n low mid-LAP: outputs return to reset values asynchronously.
